// File: rtl/rgb_pwm_decoder.sv
// rgb_pwm_decoder: recovers three PWM intensities once per frame window
// and presents them on a ready/valid interface.

module rgb_pwm_chan #(
    parameter int PWM_BITS    = 4,
    parameter int SLOT_CYCLES = 512,
    parameter int SYNC_STAGES = 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                i_pwm_n,
    input  logic                i_win_end,
    output logic [PWM_BITS-1:0] o_level
);

    localparam int WINDOW = (2 ** PWM_BITS) * SLOT_CYCLES;
    localparam int CW     = $clog2(WINDOW);
    localparam int AW     = CW + 1;
    localparam int SB     = $clog2(SLOT_CYCLES);
    localparam int HALF   = SLOT_CYCLES / 2;

    localparam logic [PWM_BITS-1:0] MAXV = '1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [AW-1:0]          r_acc;
    logic                   w_active;
    logic [AW-1:0]          w_total;
    logic [AW-1:0]          w_round;
    logic [AW-1:0]          w_quot;

    // Synchronise the asynchronous line; idle (high) out of reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pwm_n};
        end
    end

    assign w_active = ~r_sync[SYNC_STAGES-1];
    assign w_total  = r_acc + AW'(w_active);
    assign w_round  = w_total + AW'(HALF);
    assign w_quot   = w_round >> SB;

    // Count active cycles; restart at every window end
    always_ff @(posedge CLK) begin
        if (RST || i_win_end) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_total;
        end
    end

    // Round to nearest slot count, clamp a full window to the max level
    always_comb begin
        o_level = w_quot[PWM_BITS-1:0];
        if (w_quot > {{(AW-PWM_BITS){1'b0}}, MAXV}) begin
            o_level = MAXV;
        end
    end

endmodule

module rgb_pwm_decoder #(
    parameter int PWM_BITS    = 4,
    parameter int SLOT_CYCLES = 512,
    parameter int SYNC_STAGES = 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                PWM_R,
    input  logic                PWM_G,
    input  logic                PWM_B,
    output logic [PWM_BITS-1:0] R_INT,
    output logic [PWM_BITS-1:0] G_INT,
    output logic [PWM_BITS-1:0] B_INT,
    output logic                VALID,
    input  logic                READY,
    output logic                CHANGED,
    output logic                OVERRUN
);

    localparam int WINDOW = (2 ** PWM_BITS) * SLOT_CYCLES;
    localparam int CW     = $clog2(WINDOW);

    localparam logic [CW-1:0] LAST = '1;

    logic [CW-1:0]       r_cnt;
    logic                w_win_end;
    logic [PWM_BITS-1:0] w_r;
    logic [PWM_BITS-1:0] w_g;
    logic [PWM_BITS-1:0] w_b;
    logic                w_diff;

    assign w_win_end = (r_cnt == LAST);

    // Free-running window counter; wraps naturally at WINDOW
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    rgb_pwm_chan #(
        .PWM_BITS    (PWM_BITS),
        .SLOT_CYCLES (SLOT_CYCLES),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_r (
        .CLK       (CLK),
        .RST       (RST),
        .i_pwm_n   (PWM_R),
        .i_win_end (w_win_end),
        .o_level   (w_r)
    );

    rgb_pwm_chan #(
        .PWM_BITS    (PWM_BITS),
        .SLOT_CYCLES (SLOT_CYCLES),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_g (
        .CLK       (CLK),
        .RST       (RST),
        .i_pwm_n   (PWM_G),
        .i_win_end (w_win_end),
        .o_level   (w_g)
    );

    rgb_pwm_chan #(
        .PWM_BITS    (PWM_BITS),
        .SLOT_CYCLES (SLOT_CYCLES),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_b (
        .CLK       (CLK),
        .RST       (RST),
        .i_pwm_n   (PWM_B),
        .i_win_end (w_win_end),
        .o_level   (w_b)
    );

    // The outputs only move on a load, so they hold the last-loaded triple
    assign w_diff = ({w_r, w_g, w_b} != {R_INT, G_INT, B_INT});

    // Load at window end, drop VALID on transfer, flag lost triples
    always_ff @(posedge CLK) begin
        if (RST) begin
            R_INT   <= '0;
            G_INT   <= '0;
            B_INT   <= '0;
            VALID   <= 1'b0;
            CHANGED <= 1'b0;
            OVERRUN <= 1'b0;
        end else if (w_win_end) begin
            R_INT   <= w_r;
            G_INT   <= w_g;
            B_INT   <= w_b;
            VALID   <= 1'b1;
            CHANGED <= w_diff;
            if (VALID && !READY) begin
                OVERRUN <= 1'b1;
            end
        end else if (VALID && READY) begin
            VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rgb_pwm_decoder.sv
// tb_rgb_pwm_decoder: directed vectors with hand-computed expectations
// for a 4-bit, 4-cycle-slot (64-cycle window) decoder.

module tb_rgb_pwm_decoder;

    logic       CLK;
    logic       RST;
    logic       PWM_R;
    logic       PWM_G;
    logic       PWM_B;
    logic [3:0] R_INT;
    logic [3:0] G_INT;
    logic [3:0] B_INT;
    logic       VALID;
    logic       READY;
    logic       CHANGED;
    logic       OVERRUN;

    int vectors;
    int miscompares;
    int t;
    int ph;
    int low_r;
    int low_g;
    int low_b;

    rgb_pwm_decoder #(
        .PWM_BITS    (4),
        .SLOT_CYCLES (4),
        .SYNC_STAGES (2)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .PWM_R   (PWM_R),
        .PWM_G   (PWM_G),
        .PWM_B   (PWM_B),
        .R_INT   (R_INT),
        .G_INT   (G_INT),
        .B_INT   (B_INT),
        .VALID   (VALID),
        .READY   (READY),
        .CHANGED (CHANGED),
        .OVERRUN (OVERRUN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one 64-cycle-periodic frame pattern per cycle, then step a clock
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            PWM_R = (((t + ph) % 64) < low_r) ? 1'b0 : 1'b1;
            PWM_G = (((t + ph) % 64) < low_g) ? 1'b0 : 1'b1;
            PWM_B = (((t + ph) % 64) < low_b) ? 1'b0 : 1'b1;
            @(posedge CLK);
            t++;
            #1;
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        t = 0;
    endtask

    task automatic pat(input int p, input int r, input int g, input int b);
        ph    = p;
        low_r = r;
        low_g = g;
        low_b = b;
    endtask

    task automatic chk_rgb(input string tag, input int r, input int g, input int b);
        chk({tag, "_r"}, int'(R_INT), r);
        chk({tag, "_g"}, int'(G_INT), g);
        chk({tag, "_b"}, int'(B_INT), b);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        t           = 0;
        RST         = 1'b1;
        READY       = 1'b0;
        PWM_R       = 1'b1;
        PWM_G       = 1'b1;
        PWM_B       = 1'b1;
        pat(0, 0, 0, 0);
        repeat (3) @(posedge CLK);
        #1;

        chk("rst_valid", int'(VALID), 0);
        chk("rst_overrun", int'(OVERRUN), 0);
        chk("rst_changed", int'(CHANGED), 0);
        chk_rgb("rst", 0, 0, 0);

        // 1: idle lines
        do_reset();
        run(63);
        chk("t1_valid_63", int'(VALID), 0);
        run(1);
        chk("t1_valid_64", int'(VALID), 1);
        chk_rgb("t1", 0, 0, 0);
        chk("t1_changed", int'(CHANGED), 0);
        chk("t1_overrun", int'(OVERRUN), 0);

        // 2: misaligned frames, consumer always ready
        READY = 1'b1;
        pat(47, 60, 32, 0);
        do_reset();
        run(64);
        chk("t2_valid_a", int'(VALID), 1);
        chk_rgb("t2a", 15, 8, 0);
        chk("t2_changed_a", int'(CHANGED), 1);
        run(1);
        chk("t2_valid_drop", int'(VALID), 0);
        run(63);
        chk("t2_valid_b", int'(VALID), 1);
        chk_rgb("t2b", 15, 8, 0);
        chk("t2_changed_b", int'(CHANGED), 0);
        chk("t2_overrun", int'(OVERRUN), 0);
        READY = 1'b0;

        // 3: rounding and saturation
        pat(0, 5, 1, 2);
        do_reset();
        run(64);
        chk_rgb("t3a", 1, 0, 1);
        pat(0, 6, 64, 10);
        do_reset();
        run(64);
        chk_rgb("t3b", 2, 15, 3);
        pat(0, 64, 0, 0);
        do_reset();
        run(64);
        chk_rgb("t3c", 15, 0, 0);
        run(64);
        chk_rgb("t3c_full", 15, 0, 0);

        // 4: overwrite while stalled
        pat(0, 5, 1, 2);
        do_reset();
        run(64);
        chk_rgb("t4a", 1, 0, 1);
        chk("t4_overrun_a", int'(OVERRUN), 0);
        pat(0, 6, 64, 10);
        run(64);
        chk("t4_valid_b", int'(VALID), 1);
        chk_rgb("t4b", 2, 15, 3);
        chk("t4_overrun_b", int'(OVERRUN), 1);
        chk("t4_changed_b", int'(CHANGED), 1);
        READY = 1'b1;
        run(1);
        READY = 1'b0;
        chk("t4_valid_drop", int'(VALID), 0);
        chk("t4_overrun_sticky", int'(OVERRUN), 1);
        run(5);
        chk("t4_valid_stays0", int'(VALID), 0);

        // 5: transfer on the window-end cycle
        pat(0, 5, 1, 2);
        do_reset();
        run(64);
        chk("t5_valid_a", int'(VALID), 1);
        pat(0, 6, 64, 10);
        run(63);
        chk("t5_valid_hold", int'(VALID), 1);
        chk_rgb("t5_hold", 1, 0, 1);
        READY = 1'b1;
        run(1);
        READY = 1'b0;
        chk("t5_valid_b", int'(VALID), 1);
        chk_rgb("t5b", 2, 15, 3);
        chk("t5_overrun", int'(OVERRUN), 0);

        // 6: reset mid-window with a triple pending
        pat(0, 64, 0, 0);
        do_reset();
        run(64);
        chk("t6_valid_a", int'(VALID), 1);
        chk_rgb("t6a", 15, 0, 0);
        run(30);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        chk("t6_valid_rst", int'(VALID), 0);
        chk_rgb("t6_rst", 0, 0, 0);
        chk("t6_overrun_rst", int'(OVERRUN), 0);
        RST = 1'b0;
        t = 0;
        pat(0, 0, 0, 0);
        run(63);
        chk("t6_valid_63", int'(VALID), 0);
        run(1);
        chk("t6_valid_64", int'(VALID), 1);
        chk_rgb("t6b", 0, 0, 0);
        chk("t6_changed", int'(CHANGED), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
